mmio_uart_bridge: RTL and testbench

Sits between the core's memory port and the memory model and decodes a small memory-mapped I/O window. Stores to the TX data register are queued in a FIFO and serialized 8N1 on `uart_tx`; a store to 0xFFC raises a sticky `halt`. All other accesses pass straight through to memory. This gives test programs a real output device and a clean stop mechanism.

---
 rtl/mmio_uart_pkg.sv | 41 ++++
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/mmio_uart_bridge.sv | 193 +++++++++++++++++++
 tb/tb_mmio_uart_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the MMIO UART bridge: register map,
// STATUS bit layout, address decode classes and the transmitter states.
package mmio_uart_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h0000_0800;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0804;
  localparam logic [31:0] ADDR_HALT   = 32'h0000_0FFC;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;

  // Bit of a STATUS store that clears the sticky overflow flag.
  localparam int STAT_CLR_OVERFLOW = 3;

  typedef enum logic [1:0] {
    DEC_MEM,
    DEC_TXDATA,
    DEC_STATUS,
    DEC_HALT
  } decode_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic decode_e decode_addr(input logic [31:0] addr);
    decode_e d;
    d = DEC_MEM;
    if (addr == ADDR_TXDATA) d = DEC_TXDATA;
    else if (addr == ADDR_STATUS) d = DEC_STATUS;
    else if (addr == ADDR_HALT) d = DEC_HALT;
    return d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap bit
// so full and empty are distinguishable and count is a plain subtraction.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // push/pop are single-cycle requests judged against pre-edge full/empty:
  // a push while full and a pop while empty are ignored; otherwise both happen.
  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (count == (AW + 1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW + 1)'(1);
      if (do_pop)  rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Core-to-memory bridge that carves out a TX UART and a halt flag from the
// address space; every other access passes straight through to memory.
module mmio_uart_bridge
  import mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] core_address,
  input  logic [31:0] core_data_out,
  input  logic        core_write_enable,
  output logic [31:0] core_data_in,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data_out,
  output logic        uart_tx,
  output logic        halt
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);

  decode_e     dec;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_halt;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FAW:0] fifo_count;
  logic [3:0]  count4;

  logic        overflow;
  logic        halt_q;
  logic        busy;
  logic [31:0] status_word;

  tx_state_e   tx_state;
  tx_state_e   tx_state_nx;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_nx;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_nx;
  logic [7:0]  shift_q;
  logic [7:0]  shift_nx;
  logic        tx_q;
  logic        tx_nx;
  logic        baud_done;

  assign dec              = decode_addr(core_address);
  assign wr_txdata        = core_write_enable && (dec == DEC_TXDATA);
  assign wr_status        = core_write_enable && (dec == DEC_STATUS);
  assign wr_halt          = core_write_enable && (dec == DEC_HALT);

  assign mem_address      = core_address;
  assign mem_data_in      = core_data_out;
  assign mem_write_enable = core_write_enable && (dec == DEC_MEM);

  assign fifo_push = wr_txdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (core_data_out[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign count4 = 4'(fifo_count);
  assign busy   = (tx_state != TX_IDLE);

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_OVERFLOW] = overflow;
    status_word[STAT_COUNT_LSB +: 4] = count4;
  end

  always_comb begin
    core_data_in = mem_data_out;
    unique case (dec)
      DEC_TXDATA: core_data_in = '0;
      DEC_STATUS: core_data_in = status_word;
      DEC_HALT:   core_data_in = {31'b0, halt_q};
      default:    core_data_in = mem_data_out;
    endcase
  end

  // A drop on a full FIFO and a clear via STATUS never coincide: they are
  // stores to different addresses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      if (wr_txdata && fifo_full) overflow <= 1'b1;
      else if (wr_status && core_data_out[STAT_CLR_OVERFLOW]) overflow <= 1'b0;
      if (wr_halt) halt_q <= 1'b1;
    end
  end

  assign halt = halt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift_q  <= shift_nx;
      tx_q     <= tx_nx;
    end
  end

  assign baud_done = (baud_cnt == '0);

  // tx_nx is the line level for the cycle after this edge, so every state
  // computes the level of the bit it is about to enter.
  always_comb begin
    tx_state_nx = tx_state;
    baud_nx     = baud_cnt;
    bit_nx      = bit_cnt;
    shift_nx    = shift_q;
    tx_nx       = tx_q;
    fifo_pop    = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_nx = 1'b1;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_nx    = fifo_rdata;
          baud_nx     = BAUD_TOP;
          tx_nx       = 1'b0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_nx     = BAUD_TOP;
          bit_nx      = 3'd0;
          tx_nx       = shift_q[0];
          tx_state_nx = TX_DATA;
        end else begin
          baud_nx = baud_cnt - BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_nx = BAUD_TOP;
          if (bit_cnt == 3'd7) begin
            tx_nx       = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            bit_nx   = bit_cnt + 3'd1;
            shift_nx = {1'b0, shift_q[7:1]};
            tx_nx    = shift_q[1];
          end
        end else begin
          baud_nx = baud_cnt - BW'(1);
        end
      end
      TX_STOP: begin
        tx_nx = 1'b1;
        if (baud_done) tx_state_nx = TX_IDLE;
        else baud_nx = baud_cnt - BW'(1);
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Bench for mmio_uart_bridge: decode vector table, directed frame/overflow/
// halt/reset sequences, and randomized traffic against a timestamp-based model.
module tb_mmio_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX   = 32'h0000_0800;
  localparam logic [31:0] A_ST   = 32'h0000_0804;
  localparam logic [31:0] A_HALT = 32'h0000_0FFC;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] core_address = '0;
  logic [31:0] core_data_out = '0;
  logic        core_write_enable = 1'b0;
  logic [31:0] core_data_in;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_write_enable;
  logic [31:0] mem_data_out;
  logic        uart_tx;
  logic        halt;

  mmio_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .core_address      (core_address),
    .core_data_out     (core_data_out),
    .core_write_enable (core_write_enable),
    .core_data_in      (core_data_in),
    .mem_address       (mem_address),
    .mem_data_in       (mem_data_in),
    .mem_write_enable  (mem_write_enable),
    .mem_data_out      (mem_data_out),
    .uart_tx           (uart_tx),
    .halt              (halt)
  );

  // small memory behind the bridge, aliased on address bits [7:2]
  logic [31:0] tb_mem [0:63];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (mem_write_enable) begin
      tb_mem[mem_address[7:2]] <= mem_data_in;
    end
  end
  always_comb mem_data_out = tb_mem[mem_address[7:2]];

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, transmitter as a timestamp
  logic [7:0] m_q[$];
  int m_edge;
  int m_free;
  logic m_ovf;
  logic m_halt;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_edge = 0;
    m_free = 0;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
  endtask

  // One frame occupies 10*CPB cycles; the transmitter may start the next one
  // on the edge after that.
  task automatic model_step();
    logic do_pop;
    do_pop = (m_q.size() > 0) && (m_edge >= m_free);
    if (core_write_enable) begin
      if (core_address == A_TX) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(core_data_out[7:0]);
      end else if (core_address == A_ST) begin
        if (core_data_out[3]) m_ovf = 1'b0;
      end else if (core_address == A_HALT) begin
        m_halt = 1'b1;
      end
    end
    if (do_pop) begin
      exp_q.push_back(m_q.pop_front());
      m_free = m_edge + 10 * CPB + 1;
    end
    m_edge++;
  endtask

  function automatic logic [31:0] m_status();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {24'b0, c, m_ovf, (m_edge < m_free), (m_q.size() == DEPTH), (m_q.size() == 0)};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == A_TX) return 32'h0;
    if (a == A_ST) return m_status();
    if (a == A_HALT) return {31'b0, m_halt};
    return tb_mem[a[7:2]];
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    if (resetn) model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    core_address      = a;
    core_data_out     = d;
    core_write_enable = we;
    #2;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cyc();
      done = (m_q.size() == 0) && (exp_q.size() == 0) && (m_edge >= m_free);
    end
    repeat (2) cyc();
    check("drain_done", {31'b0, done}, 32'h1);
  endtask

  // serial decoder: finds a start bit and samples each bit CPB cycles apart
  initial begin
    logic [7:0] b;
    logic       stop_bit;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (resetn && uart_tx === 1'b0) begin
        aborted = 1'b0;
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            if (!resetn) aborted = 1'b1;
          end
          b[i] = uart_tx;
        end
        for (int j = 0; j < CPB; j++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
        end
        stop_bit = uart_tx;
        if (!aborted) begin
          check("rx_stop", {31'b0, stop_bit}, 32'h1);
          rx_log.push_back(b);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_unexpected: got byte %h expected none at %0t", b, $time);
          end else begin
            check("rx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rd;
    logic        exp_mwe;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    int          r;
    int          bad;

    vt[0]  = '{A_ST,          32'h0,        1'b0, 32'h0000_0001, 1'b0};
    vt[1]  = '{A_HALT,        32'h0,        1'b0, 32'h0000_0000, 1'b0};
    vt[2]  = '{A_TX,          32'h0,        1'b0, 32'h0000_0000, 1'b0};
    vt[3]  = '{32'h0000_0100, 32'h0,        1'b0, 32'hC0DE_0000, 1'b0};
    vt[4]  = '{32'h0000_0104, 32'h1234_5678, 1'b1, 32'hC0DE_0001, 1'b1};
    vt[5]  = '{32'h0000_0104, 32'h0,        1'b0, 32'h1234_5678, 1'b0};
    vt[6]  = '{32'h0000_0801, 32'h0000_00AA, 1'b1, 32'hC0DE_0000, 1'b1};
    vt[7]  = '{32'h1000_0800, 32'h0,        1'b0, 32'h0000_00AA, 1'b0};
    vt[8]  = '{A_ST,          32'h0,        1'b1, 32'h0000_0001, 1'b0};
    vt[9]  = '{32'h0000_0FFD, 32'h0,        1'b0, 32'hC0DE_003F, 1'b0};
    vt[10] = '{32'h0000_0808, 32'h5,        1'b1, 32'hC0DE_0002, 1'b1};
    vt[11] = '{A_TX,          32'h0,        1'b0, 32'h0000_0000, 1'b0};

    // 1: reset state and decode table
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #2;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_mwe", {31'b0, mem_write_enable}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].addr, vt[i].wdata, vt[i].we);
      check("vec_rdata", core_data_in, vt[i].exp_rd);
      check("vec_mwe", {31'b0, mem_write_enable}, {31'b0, vt[i].exp_mwe});
      check("vec_maddr", mem_address, vt[i].addr);
      check("vec_mdata", mem_data_in, vt[i].wdata);
      cyc();
    end

    // 2: single 0x55 frame timing
    drive(A_TX, 32'h55, 1'b1);
    check("t2_mwe_store", {31'b0, mem_write_enable}, 32'h0);
    cyc();
    drive(A_ST, 32'h0, 1'b0);
    check("t2_tx_k0", {31'b0, uart_tx}, 32'h1);
    check("t2_status_k0", core_data_in, 32'h0000_0010);
    for (int k = 1; k <= 41; k++) begin
      logic [7:0] pat;
      logic       exp_tx;
      pat = 8'h55;
      cyc();
      #2;
      if (k <= 4) exp_tx = 1'b0;
      else if (k <= 36) exp_tx = pat[(k - 5) / 4];
      else exp_tx = 1'b1;
      check("t2_tx", {31'b0, uart_tx}, {31'b0, exp_tx});
      check("t2_status", core_data_in, (k <= 40) ? 32'h0000_0005 : 32'h0000_0001);
      check("t2_mwe", {31'b0, mem_write_enable}, 32'h0);
    end

    // 3: burst of six stores into a 4-deep FIFO
    rx_log.delete();
    for (int i = 0; i < 6; i++) begin
      drive(A_TX, 32'h41 + 32'(i), 1'b1);
      cyc();
    end
    drive(A_ST, 32'h0, 1'b0);
    check("t3_status_full", core_data_in, 32'h0000_004E);
    check("t3_status_model", core_data_in, m_status());
    drive(A_ST, 32'h8, 1'b1);
    cyc();
    drive(A_ST, 32'h0, 1'b0);
    check("t3_status_clr", core_data_in, 32'h0000_0046);
    drain();
    check("t3_rx_count", 32'(rx_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      check("t3_rx_order", {24'b0, rx_log[i]}, 32'h41 + 32'(i));

    // 4: memory pass-through
    drive(32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    check("t4_mwe", {31'b0, mem_write_enable}, 32'h1);
    cyc();
    drive(32'h0000_0100, 32'h0, 1'b0);
    check("t4_load", core_data_in, 32'hDEAD_BEEF);
    drive(A_TX, 32'h0, 1'b0);
    check("t4_load_tx", core_data_in, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      d  = $urandom;
      we = 1'b0;
      if (r < 35) begin
        a = $urandom;
        if (a == A_TX || a == A_ST || a == A_HALT) a = a ^ 32'h8000_0000;
        we = 1'($urandom_range(0, 1));
      end else if (r < 60) begin
        a = A_TX;
        we = 1'b1;
      end else if (r < 85) begin
        a = A_ST;
      end else if (r < 92) begin
        a = A_HALT;
      end else if (r < 97) begin
        a = A_ST;
        we = 1'b1;
      end else begin
        a = A_TX;
      end
      drive(a, d, we);
      check("rnd_rdata", core_data_in, m_read(a));
      check("rnd_mwe", {31'b0, mem_write_enable},
            {31'b0, we && a != A_TX && a != A_ST && a != A_HALT});
      cyc();
    end
    drive(A_ST, 32'h0, 1'b0);
    drain();
    check("rnd_final_status", core_data_in, m_status());

    // 5: halt is sticky and traffic still flows
    drive(A_HALT, $urandom, 1'b1);
    check("t5_mwe", {31'b0, mem_write_enable}, 32'h0);
    check("t5_halt_before", {31'b0, halt}, 32'h0);
    cyc();
    drive(A_HALT, 32'h0, 1'b0);
    check("t5_halt_after", {31'b0, halt}, 32'h1);
    check("t5_load_halt", core_data_in, 32'h1);
    drive(32'h0000_0040, 32'hCAFE_F00D, 1'b1);
    check("t5_mem_mwe", {31'b0, mem_write_enable}, 32'h1);
    cyc();
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      if (a == A_TX || a == A_ST || a == A_HALT) a = a ^ 32'h8000_0000;
      drive(a, $urandom, 1'($urandom_range(0, 1)));
      cyc();
      #1;
      check("t5_halt_sticky", {31'b0, halt}, 32'h1);
    end
    drive(32'h0000_0040, 32'h0, 1'b0);
    check("t5_mem_load", core_data_in, 32'hCAFE_F00D);

    // 6: reset in the middle of a frame
    drive(A_TX, 32'h00, 1'b1);
    cyc();
    drive(A_ST, 32'h0, 1'b0);
    repeat (9) cyc();
    #1;
    check("t6_tx_data_low", {31'b0, uart_tx}, 32'h0);
    resetn = 1'b0;
    model_reset();
    #1;
    check("t6_tx_async_high", {31'b0, uart_tx}, 32'h1);
    check("t6_halt_cleared", {31'b0, halt}, 32'h0);
    check("t6_status_in_reset", core_data_in, 32'h1);
    repeat (3) cyc();
    resetn = 1'b1;
    #2;
    check("t6_status_after", core_data_in, 32'h1);
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (uart_tx !== 1'b1) bad++;
    end
    check("t6_no_resume", 32'(bad), 32'd0);
    check("t6_status_end", core_data_in, 32'h1);
    check("t6_rx_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
